// File: rtl/odpc_dual_lane_acc.sv
// Dual-lane accumulate-and-compare stage: sums N_TERMS products per lane,
// then reports lane-A sign, lane agreement and a saturating mismatch count.
module odpc_dual_lane_acc #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 20,
  parameter int N_TERMS = 9,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod_a,
  input  logic [PROD_W-1:0] prod_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              msb_result,
  output logic              same,
  output logic [ACC_W-1:0]  acc_a_out,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    ACC,
    CMP,
    OUT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc_a;
  logic [ACC_W-1:0] acc_b;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] ext_a;
  logic [ACC_W-1:0] ext_b;

  assign ext_a = {{(ACC_W-PROD_W){prod_a[PROD_W-1]}}, prod_a};
  assign ext_b = {{(ACC_W-PROD_W){prod_b[PROD_W-1]}}, prod_b};

  // Handshake outputs depend on state only, never on in_valid.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ACC;
    end else begin
      unique case (state)
        ACC: if (in_valid && cnt == LAST) state_nxt = CMP;
        CMP: state_nxt = OUT;
        OUT: if (out_ready) state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACC;
      acc_a      <= '0;
      acc_b      <= '0;
      cnt        <= '0;
      err_cnt    <= '0;
      acc_a_out  <= '0;
      msb_result <= 1'b0;
      same       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        acc_a <= '0;
        acc_b <= '0;
        cnt   <= '0;
      end else begin
        unique case (state)
          ACC: begin
            if (in_valid) begin
              acc_a <= acc_a + ext_a;
              acc_b <= acc_b + ext_b;
              cnt   <= cnt + 1'b1;
            end
          end
          CMP: begin
            msb_result <= acc_a[ACC_W-1];
            same       <= (acc_a == acc_b);
            acc_a_out  <= acc_a;
            if (acc_a != acc_b && err_cnt != ERR_MAX)
              err_cnt <= err_cnt + 1'b1;
          end
          OUT: begin
            if (out_ready) begin
              acc_a <= '0;
              acc_b <= '0;
              cnt   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/odpc_dual_lane_acc.md
# odpc_dual_lane_acc

Duplicated-lane accumulate-and-compare stage of the ODPC datapath, directly upstream of the output register stage. It accumulates N_TERMS signed partial products from two redundant MAC lanes (A and B) per output window. At window end it produces the sign bit of the lane-A sum (`msb_result`) and a lane-agreement flag (`same`), which the output register stage consumes to decide the final fault-tolerant result bit. It also keeps a saturating count of windows in which the two lanes disagreed.

## Interface

**Parameters**
- PROD_W, 16: width of each signed lane product.
- ACC_W, 20: accumulator width; must be ≥ PROD_W + clog2(N_TERMS).
- N_TERMS, 9: products per window (3x3 kernel); must be ≥ 2.
- ERR_W, 8: width of the mismatch counter.

**Ports**
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous window abort, active-high.
- in_valid  input  1  lane products valid.
- in_ready  output  1  stage accepts a product pair this cycle.
- prod_a  input  PROD_W  signed product, lane A.
- prod_b  input  PROD_W  signed product, lane B.
- out_valid  output  1  window result valid.
- out_ready  input  1  downstream accepts result.
- msb_result  output  1  bit ACC_W-1 of the lane-A sum.
- same  output  1  1 when the lane-A sum equals the lane-B sum.
- acc_a_out  output  ACC_W  registered lane-A sum, for debug.
- err_cnt  output  ERR_W  saturating count of mismatched windows.

## Operation

- **FSM states:** ACC, CMP, OUT. Reset state is ACC.
- **ACC:**
  - in_ready=1.
  - On in_valid: acc_a += sext(prod_a), acc_b += sext(prod_b), cnt++.
  - The beat with cnt==N_TERMS-1 moves the FSM to CMP.
- **CMP:**
  - in_ready=0.
  - Registers msb_result=acc_a[ACC_W-1], same=(acc_a==acc_b), acc_a_out=acc_a.
  - If acc_a!=acc_b, err_cnt increments; it saturates at 2^ERR_W-1.
  - Moves to OUT.
- **OUT:**
  - out_valid=1 and in_ready=0.
  - msb_result, same and acc_a_out are held stable.
  - On out_ready: clear acc_a, acc_b and cnt, then go to ACC.
- **Arithmetic:** products are sign-extended to ACC_W and sums wrap modulo 2^ACC_W. There is no overflow flag.
- **clr:**
  - Any state goes to ACC.
  - acc_a, acc_b and cnt are zeroed and out_valid drops next cycle.
  - err_cnt, msb_result, same and acc_a_out keep their values.
  - clr has priority over in_valid and out_ready in the same cycle. A beat presented with clr is discarded.
- **Reset:**
  - Asynchronous, from any state, mid-window included.
  - state=ACC; acc_a, acc_b, cnt, err_cnt and acc_a_out = 0.
  - msb_result=0, same=0, out_valid=0.
  - in_ready is 1 while reset is asserted and after release.
- **err_cnt:** only reset clears it.

## Timing

- in_ready is combinational from state only. It never depends on in_valid.
- A beat transfers on a rising edge with in_valid & in_ready.
- **Latency:**
  - Last beat accepted at edge t → CMP during cycle t..t+1.
  - out_valid=1 from edge t+1 onward.
- **Handshake:**
  - The result transfers on the first edge with out_valid & out_ready.
  - in_ready rises the cycle after that edge.
  - The next beat is accepted no earlier than one edge later.
- **Throughput:** N_TERMS+2 cycles per window minimum, with in_valid and out_ready held high.
- **Input/output rules:**
  - in_valid gaps in ACC stall accumulation without losing state.
  - in_valid during CMP or OUT is ignored, since in_ready=0.
- **Output stability:** msb_result and same change only on the CMP→OUT edge, on clr/reset (msb_result and same reset only), never during OUT. This guarantees the downstream register samples stable values across both of its reset-phase edges.

## Test plan

- **Reset:** assert reset mid-window after 4 beats → in_ready=1, out_valid=0, err_cnt=0. A fresh 9-beat window then produces a correct result.
- **Matched lanes:** 9 beats of prod_a=prod_b=16'sd100 → out_valid at the edge after the last beat, acc_a_out=900, msb_result=0, same=1, err_cnt=0.
- **Negative sum and stall:**
  - 9 beats of prod_a=prod_b=-16'sd1000 with in_valid toggled 1/0 → acc_a_out=20'hFDCD8 (-9000), msb_result=1, same=1.
  - Hold out_ready=0 for 5 cycles → outputs stay stable, in_ready=0.
- **Mismatch and saturation:**
  - One beat of prod_b differs by 1 → same=0, err_cnt increments by 1.
  - Repeat 300 mismatched windows → err_cnt=255.
- **Wrap-around:** 9 beats of prod_a=prod_b=16'sh7FFF with ACC_W=17 → sum wraps modulo 2^17, msb_result matches bit 16 of 9×32767 mod 2^17, same=1.
- **clr:**
  - Assert clr with in_valid after 5 beats → beat discarded, next window starts from zero.
  - Assert clr during OUT → out_valid=0 next cycle, err_cnt unchanged.
